// File: rtl/rom_arbiter.sv
// Shares one combinational ROM between IF and DM readers; IF has priority, DM is forced after STARVE_MAX IF wins.
// Latency 1 (grant N -> valid N+1); losers wait with req held, no internal buffering.
module rom_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ROM_BLOCK  = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_valid,
  output logic [DATA_WIDTH-1:0] o_if_data,
  output logic                  o_if_err,
  input  logic                  i_dm_req,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  output logic                  o_dm_gnt,
  output logic                  o_dm_valid,
  output logic [DATA_WIDTH-1:0] o_dm_data,
  output logic                  o_dm_err,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_WIDTH:0] ROM_LIMIT = (ADDR_WIDTH + 1)'(ROM_BLOCK);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  typedef enum logic {IF_PRIO, DM_FORCE} state_t;

  state_t                state;
  logic [CW-1:0]         starve_cnt;
  logic                  if_gnt;
  logic                  dm_gnt;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] rom_addr;

  logic                  if_valid_q;
  logic                  if_err_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic                  dm_valid_q;
  logic                  dm_err_q;
  logic [DATA_WIDTH-1:0] dm_data_q;

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!i_rst) begin
      if (state == DM_FORCE) begin
        dm_gnt = i_dm_req;
        if_gnt = i_if_req && !i_dm_req;
      end else begin
        if_gnt = i_if_req;
        dm_gnt = i_dm_req && !i_if_req;
      end
    end
  end

  assign rom_addr = if_gnt ? i_if_addr : (dm_gnt ? i_dm_addr : '0);
  // Widened compare so large addresses never alias back into the ROM range
  assign addr_err = {1'b0, rom_addr} >= ROM_LIMIT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IF_PRIO;
      starve_cnt <= '0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      if_data_q  <= '0;
      dm_valid_q <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_data_q  <= '0;
    end else begin
      if_valid_q <= if_gnt;
      if_err_q   <= if_gnt && addr_err;
      dm_valid_q <= dm_gnt;
      dm_err_q   <= dm_gnt && addr_err;
      if (if_gnt) if_data_q <= addr_err ? '0 : i_rom_data;
      if (dm_gnt) dm_data_q <= addr_err ? '0 : i_rom_data;

      state <= IF_PRIO;
      if (dm_gnt || !i_dm_req) begin
        starve_cnt <= '0;
      end else if (if_gnt) begin
        if (starve_cnt == CNT_LAST) begin
          starve_cnt <= '0;
          state      <= DM_FORCE;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

  // Responses registered before reset asserted must not leak out during reset
  assign o_if_gnt   = if_gnt;
  assign o_dm_gnt   = dm_gnt;
  assign o_rom_addr = rom_addr;
  assign o_if_valid = if_valid_q && !i_rst;
  assign o_if_err   = if_err_q && !i_rst;
  assign o_if_data  = i_rst ? '0 : if_data_q;
  assign o_dm_valid = dm_valid_q && !i_rst;
  assign o_dm_err   = dm_err_q && !i_rst;
  assign o_dm_data  = i_rst ? '0 : dm_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: vector table of grant expectations, response scoreboard per port.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_if_req, i_dm_req;
  logic [31:0] i_if_addr, i_dm_addr;
  logic        o_if_gnt, o_if_valid, o_if_err;
  logic        o_dm_gnt, o_dm_valid, o_dm_err;
  logic [31:0] o_if_data, o_dm_data, o_rom_addr, i_rom_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic [31:0] dma;
    logic        eif;
    logic        edm;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  vec_t        vecs[$];
  rsp_t        if_q[$];
  rsp_t        dm_q[$];
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_dm = 32'h0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign i_rom_data = rom_fn(o_rom_addr);

  rom_arbiter dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_valid(o_if_valid), .o_if_data(o_if_data), .o_if_err(o_if_err),
    .i_dm_req(i_dm_req), .i_dm_addr(i_dm_addr), .o_dm_gnt(o_dm_gnt),
    .o_dm_valid(o_dm_valid), .o_dm_data(o_dm_data), .o_dm_err(o_dm_err),
    .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data)
  );

  function automatic rsp_t mk(input logic [31:0] a);
    rsp_t r;
    r.e = (a >= 32'd1024);
    r.d = r.e ? 32'h0 : rom_fn(a);
    return r;
  endfunction

  function automatic void add(input logic ifr, input logic [31:0] ifa, input logic dmr,
                              input logic [31:0] dma, input logic eif, input logic edm);
    vecs.push_back('{ifr, ifa, dmr, dma, eif, edm});
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa,
                      input logic dmr, input logic [31:0] dma,
                      input logic eif, input logic edm);
    rsp_t r;
    i_rst = rst; i_if_req = ifr; i_if_addr = ifa; i_dm_req = dmr; i_dm_addr = dma;
    @(negedge clk);
    if (rst) begin
      if_q.delete(); dm_q.delete();
      last_if = 32'h0; last_dm = 32'h0;
    end
    if (if_q.size() > 0) begin
      r = if_q.pop_front();
      chk1("if_valid", o_if_valid, 1'b1);
      chk32("if_data", o_if_data, r.d);
      chk1("if_err", o_if_err, r.e);
      last_if = r.d;
    end else begin
      chk1("if_valid_idle", o_if_valid, 1'b0);
      chk1("if_err_idle", o_if_err, 1'b0);
      chk32("if_data_hold", o_if_data, last_if);
    end
    if (dm_q.size() > 0) begin
      r = dm_q.pop_front();
      chk1("dm_valid", o_dm_valid, 1'b1);
      chk32("dm_data", o_dm_data, r.d);
      chk1("dm_err", o_dm_err, r.e);
      last_dm = r.d;
    end else begin
      chk1("dm_valid_idle", o_dm_valid, 1'b0);
      chk1("dm_err_idle", o_dm_err, 1'b0);
      chk32("dm_data_hold", o_dm_data, last_dm);
    end
    chk1("if_gnt", o_if_gnt, eif);
    chk1("dm_gnt", o_dm_gnt, edm);
    chk32("rom_addr", o_rom_addr, eif ? ifa : (edm ? dma : 32'h0));
    if (eif && !rst) if_q.push_back(mk(ifa));
    if (edm && !rst) dm_q.push_back(mk(dma));
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_if_req = 1'b0; i_dm_req = 1'b0; i_if_addr = '0; i_dm_addr = '0;

    // IF only, back-to-back
    add(1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0);
    add(1, 2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    // both requesting: four IF wins then a forced DM, twice
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) add(1, 32'(10 + 5 * k + i), 1, 32'(100 + k), 1, 0);
      add(1, 32'(99), 1, 32'(100 + k), 0, 1);
    end
    add(0, 0, 0, 0, 0, 0);
    // DM alone, in range then range edges
    add(0, 0, 1, 5, 0, 1);
    add(0, 0, 1, 1024, 0, 1);
    add(0, 0, 1, 1025, 0, 1);
    add(0, 0, 1, 1023, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    // IF out of range, including one that would alias under truncation
    add(1, 32'h8000_0000, 0, 0, 1, 0);
    add(1, 32'hFFFF_FFFF, 0, 0, 1, 0);
    add(1, 32'd3, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0);
    // DM dropping its request clears the starvation count
    for (int i = 0; i < 3; i++) add(1, 32'(20 + i), 1, 200, 1, 0);
    add(1, 30, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 32'(40 + i), 1, 201, 1, 0);
    add(1, 50, 1, 201, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    // forced slot with no DM request falls back to IF
    for (int i = 0; i < 4; i++) add(1, 32'(60 + i), 1, 300, 1, 0);
    add(1, 70, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 32'(80 + i), 1, 301, 1, 0);
    add(1, 90, 1, 301, 0, 1);
    add(0, 0, 0, 0, 0, 0);

    // reset held two cycles with both requesters active
    step(1, 1, 3, 1, 4, 0, 0);
    step(1, 1, 3, 1, 4, 0, 0);

    foreach (vecs[i]) step(0, vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].dma,
                           vecs[i].eif, vecs[i].edm);

    // reset right after an IF grant drops the response and clears the count
    step(0, 1, 7, 1, 400, 1, 0);
    step(0, 1, 8, 1, 400, 1, 0);
    step(0, 1, 9, 1, 400, 1, 0);
    step(1, 1, 9, 1, 400, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'(110 + i), 1, 401, 1, 0);
    step(0, 1, 120, 1, 401, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
